// File: rtl/bus_pkg.sv
`default_nettype none
//==============================================================================
// Module   : bus_pkg
// Purpose  : Shared state encoding, master indices and constants for the
//            HC800 memory bus arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int M_VIDEO = 0;
    localparam int M_CPU   = 1;
    localparam int M_DMA   = 2;

    localparam logic [7:0] ERR_DATA = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : bus_arbiter_if
// Purpose  : Master-side request bundle and memory-side strobes of the arbiter.
// Revision : 1.0 - initial release
//==============================================================================
interface bus_arbiter_if #(
    parameter int ADDR_W = 16
) ();

    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*ADDR_W-1:0] addr;
    logic [23:0]         wdata;
    logic [2:0]          ack;
    logic                err;
    logic [7:0]          rdata;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_wdata;
    logic                mem_ack;
    logic [7:0]          mem_rdata;

    // The arbiter itself
    modport slave (
        input  req, we, addr, wdata, mem_ack, mem_rdata,
        output ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    // The masters together with the memory they share
    modport master (
        output req, we, addr, wdata, mem_ack, mem_rdata,
        input  ack, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/bus_arb_select.sv
`default_nettype none
//==============================================================================
// Module   : bus_arb_select
// Purpose  : Combinational winner pick: video first unless blocked, then
//            CPU/DMA in round-robin order. One-hot grant output.
// Revision : 1.0 - initial release
//==============================================================================
module bus_arb_select
    import bus_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic       i_rr_dma,
    input  logic       i_vid_block,
    output logic [2:0] o_grant
);

    always_comb begin
        o_grant = '0;
        if (i_req[M_VIDEO] && !i_vid_block) begin
            o_grant[M_VIDEO] = 1'b1;
        end else if (i_rr_dma) begin
            if (i_req[M_DMA])      o_grant[M_DMA] = 1'b1;
            else if (i_req[M_CPU]) o_grant[M_CPU] = 1'b1;
        end else begin
            if (i_req[M_CPU])      o_grant[M_CPU] = 1'b1;
            else if (i_req[M_DMA]) o_grant[M_DMA] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : bus_arbiter
// Purpose  : Three-master HC800 memory bus arbiter; one transfer at a time
//            with video starvation limit and memory timeout.
// Revision : 1.0 - initial release
//==============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int VID_BURST = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic         bus_clk,
    input  logic         bus_reset,
    bus_arbiter_if.slave bus
);

    localparam int                   c_BURST_W   = $clog2(VID_BURST + 1);
    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(VID_BURST);
    localparam logic [7:0]           c_TMO_LAST  = 8'(TIMEOUT - 1);

    state_t                r_state,     w_state_nxt;
    logic [2:0]            r_winner,    w_winner_nxt;
    logic [2:0]            r_ack,       w_ack_nxt;
    logic                  r_err,       w_err_nxt;
    logic [7:0]            r_rdata,     w_rdata_nxt;
    logic                  r_mem_req,   w_mem_req_nxt;
    logic                  r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0]     r_mem_addr,  w_mem_addr_nxt;
    logic [7:0]            r_mem_wdata, w_mem_wdata_nxt;
    logic                  r_rr_dma,    w_rr_dma_nxt;
    logic [c_BURST_W-1:0]  r_burst,     w_burst_nxt;
    logic [7:0]            r_tcnt,      w_tcnt_nxt;

    logic                  w_lower_req;
    logic                  w_vid_block;
    logic [2:0]            w_grant;
    logic [ADDR_W-1:0]     w_addr_arr  [3];
    logic [7:0]            w_wdata_arr [3];
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [7:0]            w_sel_wdata;

    for (genvar gi = 0; gi < 3; gi++) begin : g_split
        assign w_addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = bus.wdata[gi*8 +: 8];
    end

    // Blocking video only matters while a lower master waits; otherwise a
    // lone video requester would stall forever on a saturated count.
    assign w_lower_req = bus.req[M_CPU] | bus.req[M_DMA];
    assign w_vid_block = (r_burst == c_BURST_MAX) && w_lower_req;

    bus_arb_select u_select (
        .i_req       (bus.req),
        .i_rr_dma    (r_rr_dma),
        .i_vid_block (w_vid_block),
        .o_grant     (w_grant)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_grant[i]) begin
                w_sel_addr  = w_sel_addr  | w_addr_arr[i];
                w_sel_wdata = w_sel_wdata | w_wdata_arr[i];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_winner_nxt    = r_winner;
        w_ack_nxt       = '0;
        w_err_nxt       = 1'b0;
        w_rdata_nxt     = r_rdata;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_rr_dma_nxt    = r_rr_dma;
        w_burst_nxt     = r_burst;
        w_tcnt_nxt      = r_tcnt;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_winner_nxt    = w_grant;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = |(bus.we & w_grant);
                    w_mem_addr_nxt  = w_sel_addr;
                    w_mem_wdata_nxt = w_sel_wdata;
                    w_tcnt_nxt      = '0;
                    w_state_nxt     = ST_BUSY;
                    if (w_grant[M_VIDEO]) begin
                        w_burst_nxt = w_lower_req ? r_burst + c_BURST_W'(1) : '0;
                    end else begin
                        w_burst_nxt  = '0;
                        w_rr_dma_nxt = w_grant[M_CPU];
                    end
                end
            end
            ST_BUSY: begin
                if (bus.mem_ack) begin
                    w_rdata_nxt   = bus.mem_rdata;
                    w_ack_nxt     = r_winner;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = ST_DONE;
                end else if (r_tcnt == c_TMO_LAST) begin
                    w_tcnt_nxt    = r_tcnt + 8'd1;
                    w_rdata_nxt   = ERR_DATA;
                    w_err_nxt     = 1'b1;
                    w_ack_nxt     = r_winner;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = ST_DONE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            r_state     <= ST_IDLE;
            r_winner    <= '0;
            r_ack       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rr_dma    <= 1'b0;
            r_burst     <= '0;
            r_tcnt      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_winner    <= w_winner_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_rr_dma    <= w_rr_dma_nxt;
            r_burst     <= w_burst_nxt;
            r_tcnt      <= w_tcnt_nxt;
        end
    end

    assign bus.ack       = r_ack;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
module tb_bus_arbiter;

    localparam logic [15:0] c_A_VID = 16'h0A00;
    localparam logic [15:0] c_A_CPU = 16'h0C00;
    localparam logic [15:0] c_A_DMA = 16'h0D00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt;

    bus_arbiter_if #(.ADDR_W(16)) bus ();

    bus_arbiter #(
        .ADDR_W    (16),
        .VID_BURST (4),
        .TIMEOUT   (15)
    ) dut (
        .bus_clk   (clk),
        .bus_reset (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] addr_of(input logic [2:0] g);
        case (g)
            3'b001:  return c_A_VID;
            3'b010:  return c_A_CPU;
            default: return c_A_DMA;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One transfer with immediate mem_ack, starting from IDLE with req set
    task automatic xfer(input string tag, input logic [2:0] gnt, input logic [7:0] rd);
        tick();
        check({tag, " mem_req"}, 32'(bus.mem_req), 32'd1);
        check({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(addr_of(gnt)));
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd;
        tick();
        check({tag, " ack"}, 32'(bus.ack), 32'(gnt));
        check({tag, " rdata"}, 32'(bus.rdata), 32'(rd));
        check({tag, " err"}, 32'(bus.err), 32'd0);
        bus.mem_ack = 1'b0;
        tick();
        check({tag, " ack_clear"}, 32'(bus.ack), 32'd0);
    endtask

    initial begin
        logic [2:0] burst_order [10];
        logic [2:0] rr_order    [4];

        bus.req       = '0;
        bus.we        = '0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Reset state
        do_reset();
        check("rst ack",       32'(bus.ack),       32'd0);
        check("rst err",       32'(bus.err),       32'd0);
        check("rst rdata",     32'(bus.rdata),     32'd0);
        check("rst mem_req",   32'(bus.mem_req),   32'd0);
        check("rst mem_we",    32'(bus.mem_we),    32'd0);
        check("rst mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);

        // CPU read, mem_ack two cycles after mem_req
        bus.addr = {16'h0000, 16'h1234, 16'h0000};
        bus.req  = 3'b010;
        tick();
        check("cpu mem_req",  32'(bus.mem_req),  32'd1);
        check("cpu mem_addr", 32'(bus.mem_addr), 32'h1234);
        check("cpu mem_we",   32'(bus.mem_we),   32'd0);
        tick();
        check("cpu wait mem_req", 32'(bus.mem_req), 32'd1);
        check("cpu wait ack",     32'(bus.ack),     32'd0);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hA5;
        tick();
        check("cpu ack",     32'(bus.ack),     32'b010);
        check("cpu rdata",   32'(bus.rdata),   32'hA5);
        check("cpu err",     32'(bus.err),     32'd0);
        check("cpu mem_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b0;
        bus.req     = 3'b000;
        tick();
        check("cpu ack one cycle", 32'(bus.ack), 32'd0);

        // All three requesting: video burst of 4, then a lower master
        do_reset();
        bus.addr    = {c_A_DMA, c_A_CPU, c_A_VID};
        bus.req     = 3'b111;
        burst_order = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                        3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
        for (int i = 0; i < 10; i++) begin
            xfer($sformatf("burst%0d", i), burst_order[i], 8'(8'h10 + i));
        end

        // CPU and DMA alternate with video idle
        do_reset();
        bus.req  = 3'b110;
        rr_order = '{3'b010, 3'b100, 3'b010, 3'b100};
        for (int i = 0; i < 4; i++) begin
            xfer($sformatf("rr%0d", i), rr_order[i], 8'(8'h20 + i));
        end
        bus.req = 3'b000;

        // DMA write that the memory never acknowledges
        bus.we    = 3'b100;
        bus.wdata = {8'h5C, 8'h00, 8'h00};
        bus.req   = 3'b100;
        tick();
        check("tmo mem_we",    32'(bus.mem_we),    32'd1);
        check("tmo mem_wdata", 32'(bus.mem_wdata), 32'h5C);
        cnt = bus.mem_req ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus.mem_req) break;
            cnt++;
        end
        check("tmo mem_req cycles", 32'(cnt),       32'd15);
        check("tmo ack",            32'(bus.ack),   32'b100);
        check("tmo err",            32'(bus.err),   32'd1);
        check("tmo rdata",          32'(bus.rdata), 32'hFF);
        bus.req = 3'b000;
        tick();
        check("tmo err clear", 32'(bus.err), 32'd0);

        // mem_ack on the last allowed BUSY cycle still succeeds
        bus.req = 3'b100;
        tick();
        repeat (14) tick();
        check("edge mem_req", 32'(bus.mem_req), 32'd1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h3C;
        tick();
        check("edge ack",   32'(bus.ack),   32'b100);
        check("edge err",   32'(bus.err),   32'd0);
        check("edge rdata", 32'(bus.rdata), 32'h3C);
        bus.mem_ack = 1'b0;
        bus.req     = 3'b000;
        bus.we      = 3'b000;
        tick();

        // Reset mid-BUSY, then the held CPU request wins again
        bus.req = 3'b110;
        tick();
        check("mid pre mem_addr", 32'(bus.mem_addr), 32'(c_A_CPU));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst mem_req", 32'(bus.mem_req), 32'd0);
        check("mid rst ack",     32'(bus.ack),     32'd0);
        tick();
        check("mid regrant mem_req",  32'(bus.mem_req),  32'd1);
        check("mid regrant mem_addr", 32'(bus.mem_addr), 32'(c_A_CPU));
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h77;
        tick();
        check("mid ack",   32'(bus.ack),   32'b010);
        check("mid rdata", 32'(bus.rdata), 32'h77);
        bus.mem_ack = 1'b0;

        // CPU holds req one cycle into DONE: no grant there
        tick();
        check("done no grant mem_req", 32'(bus.mem_req), 32'd0);
        check("done no grant ack",     32'(bus.ack),     32'd0);
        bus.req = 3'b100;
        tick();
        check("after done mem_req",  32'(bus.mem_req),  32'd1);
        check("after done mem_addr", 32'(bus.mem_addr), 32'(c_A_DMA));
        bus.mem_ack = 1'b1;
        tick();
        check("after done ack", 32'(bus.ack), 32'b100);
        bus.mem_ack = 1'b0;
        bus.req     = 3'b000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single HC800 memory bus between three masters: video fetch (index 0), CPU (index 1) and DMA/UART (index 2).
- The arbitration policy is:
  - video has fixed highest priority, subject to a starvation limit;
  - CPU and DMA alternate round-robin.
- Sits between the masters and the memory bus in the bus_clk domain.
- Sequences one transfer at a time, with a timeout that protects against an unresponsive memory.

Parameters:
ADDR_W, 16, address width per master
VID_BURST, 4, max consecutive video grants while a lower master waits
TIMEOUT, 15, max BUSY cycles waiting for mem_ack before abort (1..255)

Ports:
bus_clk  in  1  bus clock; all logic on rising edge
bus_reset  in  1  synchronous, active-high reset
req  in  3  per-master request, held high until its ack
we  in  3  per-master write enable, valid while req high
addr  in  3*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
wdata  in  24  per-master write data, master i at [i*8 +: 8]
ack  out  3  one-hot, one-cycle completion pulse
err  out  1  high with ack when transfer timed out
rdata  out  8  read data, valid while ack non-zero
mem_req  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  memory write data
mem_ack  in  1  memory completion (data valid same cycle)
mem_rdata  in  8  memory read data

Behaviour:
- Reset (synchronous, dominates everything):
  - state=IDLE;
  - ack=0, err=0, rdata=0;
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - rr pointer selects CPU; burst count=0; timeout count=0.
  - Reset mid-transfer aborts silently: no ack is issued.
- State IDLE:
  - If any eligible req: compute winner, register winner, latch its we/addr/wdata onto the mem_* outputs, set mem_req=1, go to BUSY.
  - If no eligible req: stay in IDLE.
- Winner selection:
  - Video wins if req[0] and not blocked.
  - Otherwise the rr-pointed master wins if requesting, else the other of CPU/DMA.
  - After a CPU or DMA grant, rr points to the other master.
- Starvation limit:
  - Burst count increments on a video grant made while req[1] or req[2] is high.
  - The count clears on any CPU/DMA grant, or on a video grant with no lower request pending.
  - When burst count == VID_BURST, video is blocked for the next arbitration only.
- State BUSY:
  - mem_* outputs are held stable.
  - On mem_ack: rdata<=mem_rdata, ack[winner]<=1, mem_req<=0, go to DONE.
  - Without mem_ack: timeout count increments. When it reaches TIMEOUT, rdata<=8'hFF, err<=1, ack[winner]<=1, mem_req<=0, go to DONE.
  - Timeout count clears on entry to BUSY.
  - A mem_ack arriving in the same cycle the count reaches TIMEOUT counts as success (err=0).
- State DONE:
  - ack/err are high for exactly this one cycle; then cleared, and the FSM returns to IDLE.
  - All req inputs are ignored in DONE. The acked master drops req in the cycle it sees ack.
- Latency:
  - A request seen in IDLE at cycle n drives mem_req from n+1.
  - With mem_ack at n+1, ack is high at n+2.
  - Minimum 3 cycles per transfer; back-to-back grants are issued every 3 cycles.
- Write transfers also produce rdata=mem_rdata at ack; masters ignore it.
- A req deasserted during BUSY does not abort the transfer; the ack is still issued.
- An ack is never asserted for more than one master, and never outside DONE.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding (ST_IDLE, ST_BUSY, ST_DONE);
  - master indices (M_VIDEO=0, M_CPU=1, M_DMA=2);
  - constant ERR_DATA=8'hFF.
- One sub-module, bus_arb_select: combinational winner selection from req, rr pointer and video-block flag, producing a one-hot grant.
- The FSM, counters and datapath latches stay in bus_arbiter.

Test Plan:
- CPU read: req=3'b010, addr=16'h1234, mem_ack 2 cycles after mem_req with mem_rdata=8'hA5 -> mem_addr=16'h1234, mem_we=0; ack=3'b010 one cycle with rdata=8'hA5, err=0.
- Simultaneous req=3'b111 held continuously -> grant order video, video, video, video, CPU, video ×4, DMA (VID_BURST=4).
- CPU and DMA both requesting continuously, video idle -> alternating grants CPU, DMA, CPU, DMA; each ack 3 cycles apart with immediate mem_ack.
- Timeout: DMA write, mem_ack never asserted -> mem_req high for exactly 15 cycles, then ack=3'b100, err=1, rdata=8'hFF; mem_ack asserted on the 15th BUSY cycle instead -> err=0.
- Reset mid-BUSY: assert bus_reset for 1 cycle during a CPU transfer -> next cycle mem_req=0, ack=0, state IDLE; a held req[1] is re-granted afterwards with rr favouring CPU.
- DONE-cycle req: master keeps req high one cycle into DONE -> no grant issued in DONE; arbitration restarts in IDLE the following cycle.
